// File: rtl/stream_config_sequencer_if.sv
// Configuration, input-port and output-port signals of stream_config_sequencer.
// The slave modport is the sequencer's view. The master modport is the surrounding fabric's view.
interface stream_config_sequencer_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int SELECT_BITS = 4,
    parameter int TYPE_BITS   = 4,
    parameter int DATA_BITS   = 512
);
    logic                            cfg_select_valid;
    logic                            cfg_select_ready;
    logic [SELECT_BITS-1:0]          cfg_select_data;
    logic                            cfg_type_valid;
    logic                            cfg_type_ready;
    logic [TYPE_BITS-1:0]            cfg_type_data;

    logic [NUM_INPUTS-1:0]           in_valid;
    logic [NUM_INPUTS-1:0]           in_ready;
    logic [NUM_INPUTS-1:0]           in_last;
    logic [NUM_INPUTS*DATA_BITS-1:0] in_data;

    logic                            out_valid;
    logic                            out_ready;
    logic                            out_last;
    logic [DATA_BITS-1:0]            out_data;
    logic [TYPE_BITS-1:0]            out_type;

    logic [31:0]                     streams_done;
    logic                            err_bad_select;

    modport master (
        output cfg_select_valid, cfg_select_data, cfg_type_valid, cfg_type_data,
        output in_valid, in_last, in_data, out_ready,
        input  cfg_select_ready, cfg_type_ready, in_ready,
        input  out_valid, out_last, out_data, out_type, streams_done, err_bad_select
    );

    modport slave (
        input  cfg_select_valid, cfg_select_data, cfg_type_valid, cfg_type_data,
        input  in_valid, in_last, in_data, out_ready,
        output cfg_select_ready, cfg_type_ready, in_ready,
        output out_valid, out_last, out_data, out_type, streams_done, err_bad_select
    );
endinterface

// File: rtl/stream_config_sequencer.sv
// Purpose: applies one joined select/type config pair to exactly one stream, routing the selected input to the output.
// Latency: the data path is combinational. A config accepted at edge N can stream from cycle N+1.
// Backpressure: out_ready drives only the selected in_ready. The config channels are held off while a stream is open.
module stream_config_sequencer #(
    parameter int NUM_INPUTS  = 4,
    parameter int SELECT_BITS = 4,
    parameter int TYPE_BITS   = 4,
    parameter int DATA_BITS   = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    stream_config_sequencer_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SELECT_BITS-1:0] sel_q;
    logic [TYPE_BITS-1:0]   type_q;
    logic [31:0]            done_q;
    logic                   err_q;

    logic                   sel_ok;
    logic                   cfg_ready;
    logic                   cfg_fire;
    logic                   last_fire;
    logic                   route_valid;
    logic                   route_last;
    logic [DATA_BITS-1:0]   route_data;
    logic [TYPE_BITS-1:0]   route_type;
    logic [NUM_INPUTS-1:0]  route_ready;

    assign sel_ok = (32'(bus.cfg_select_data) < 32'(NUM_INPUTS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A bad select is still registered, but it only raises the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            type_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cfg_fire) begin
                sel_q  <= bus.cfg_select_data;
                type_q <= bus.cfg_type_data;
                if (!sel_ok) begin
                    err_q <= 1'b1;
                end
            end
            if (last_fire) begin
                done_q <= done_q + 32'd1;
            end
        end
    end

    // Reset gates every handshake so a stream caught mid-flight is abandoned cleanly.
    always_comb begin
        state_d     = state_q;
        cfg_ready   = 1'b0;
        cfg_fire    = 1'b0;
        last_fire   = 1'b0;
        route_valid = 1'b0;
        route_last  = 1'b0;
        route_data  = '0;
        route_type  = '0;
        route_ready = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    cfg_ready = bus.cfg_select_valid & bus.cfg_type_valid;
                    cfg_fire  = cfg_ready;
                    if (cfg_fire && sel_ok) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    route_type = type_q;
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (sel_q == SELECT_BITS'(i)) begin
                            route_valid    = bus.in_valid[i];
                            route_last     = bus.in_last[i];
                            route_data     = bus.in_data[i*DATA_BITS +: DATA_BITS];
                            route_ready[i] = bus.out_ready;
                        end
                    end
                    if (route_valid && bus.out_ready && route_last) begin
                        last_fire = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.cfg_select_ready = cfg_ready;
    assign bus.cfg_type_ready   = cfg_ready;
    assign bus.in_ready         = route_ready;
    assign bus.out_valid        = route_valid;
    assign bus.out_last         = route_last;
    assign bus.out_data         = route_data;
    assign bus.out_type         = route_type;
    assign bus.streams_done     = done_q;
    assign bus.err_bad_select   = err_q;

endmodule

// File: tb/tb_stream_config_sequencer.sv
// Randomized bench for stream_config_sequencer: queue-fed sources, a stream-level reference model
// checked every cycle, and literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_stream_config_sequencer;
    localparam int NI = 4;
    localparam int SB = 4;
    localparam int TW = 4;
    localparam int DB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_config_sequencer_if #(.NUM_INPUTS(NI), .SELECT_BITS(SB), .TYPE_BITS(TW), .DATA_BITS(DB)) bus ();

    stream_config_sequencer #(.NUM_INPUTS(NI), .SELECT_BITS(SB), .TYPE_BITS(TW), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stimulus queues fed by tests, drained by the driver as the DUT handshakes
    logic [SB+TW-1:0] cfg_q[$];
    logic [DB:0]      src_q[NI][$];
    logic [TW+DB:0]   got_q[$];
    int               out_cyc[$];
    int               cfg_hs_n = 0;
    int               in_hs_n[NI] = '{default: 0};
    int               flush_req = 0;
    int               vld_pct = 100;
    int               rdy_pct = 100;
    bit               junk_vld = 1'b0;
    bit               man_cfg = 1'b0;
    bit               m_sv = 1'b0;
    bit               m_tv = 1'b0;
    logic [SB-1:0]    m_sel = '0;
    logic [TW-1:0]    m_typ = '0;
    bit               chk_en = 1'b0;
    int               cyc = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_got(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (got_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(got_q.size() >= target), 64'(1));
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [DB-1:0] d,
                            input logic l, input logic [TW-1:0] t);
        logic [TW+DB:0] g;
        if (idx >= got_q.size()) begin
            chk({name, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
        end else begin
            g = got_q[idx];
            chk({name, "_data"}, 64'(g[DB-1:0]), 64'(d));
            chk({name, "_last"}, 64'(g[DB]), 64'(l));
            chk({name, "_type"}, 64'(g[TW+DB:DB+1]), 64'(t));
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        man_cfg = 1'b0;
        m_sv    = 1'b0;
        m_tv    = 1'b0;
        flush_req++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Driver: inputs change 1ns after each rising edge
    initial begin : driver
        int          cfg_popped;
        int          in_popped[NI];
        int          flush_seen;
        bit          held[NI];
        bit          v;
        logic [DB:0] beat;
        cfg_popped = 0;
        flush_seen = 0;
        for (int i = 0; i < NI; i++) begin
            in_popped[i] = 0;
            held[i]      = 1'b0;
        end
        bus.cfg_select_valid = 1'b0;
        bus.cfg_select_data  = '0;
        bus.cfg_type_valid   = 1'b0;
        bus.cfg_type_data    = '0;
        bus.in_valid         = '0;
        bus.in_last          = '0;
        bus.in_data          = '0;
        bus.out_ready        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (flush_seen != flush_req) begin
                flush_seen = flush_req;
                cfg_q.delete();
                for (int i = 0; i < NI; i++) begin
                    src_q[i].delete();
                    held[i] = 1'b0;
                end
            end
            while (cfg_popped < cfg_hs_n) begin
                cfg_popped++;
                if (cfg_q.size() > 0) void'(cfg_q.pop_front());
            end
            if (man_cfg) begin
                bus.cfg_select_valid = m_sv;
                bus.cfg_type_valid   = m_tv;
                bus.cfg_select_data  = m_sel;
                bus.cfg_type_data    = m_typ;
            end else if (cfg_q.size() > 0) begin
                bus.cfg_select_valid = 1'b1;
                bus.cfg_type_valid   = 1'b1;
                {bus.cfg_select_data, bus.cfg_type_data} = cfg_q[0];
            end else begin
                bus.cfg_select_valid = 1'b0;
                bus.cfg_type_valid   = 1'b0;
                bus.cfg_select_data  = SB'($urandom);
                bus.cfg_type_data    = TW'($urandom);
            end
            for (int i = 0; i < NI; i++) begin
                while (in_popped[i] < in_hs_n[i]) begin
                    in_popped[i]++;
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                    held[i] = 1'b0;
                end
                v    = 1'b0;
                beat = {1'($urandom_range(1)), DB'($urandom)};
                if (src_q[i].size() > 0) begin
                    if (!held[i]) held[i] = ($urandom_range(99) < vld_pct);
                    if (held[i]) begin
                        v    = 1'b1;
                        beat = src_q[i][0];
                    end
                end else begin
                    held[i] = 1'b0;
                    v       = junk_vld;
                end
                bus.in_valid[i]         = v;
                bus.in_last[i]          = beat[DB];
                bus.in_data[i*DB +: DB] = beat[DB-1:0];
            end
            bus.out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: stream-level reference model, compared at every falling edge
    initial begin : monitor
        int              cur;
        int              s;
        logic [TW-1:0]   mtype;
        logic [31:0]     mdone;
        logic            merr;
        logic            e_cfg;
        logic            e_ov;
        logic            e_ol;
        logic [NI-1:0]   e_ir;
        logic [DB-1:0]   e_od;
        logic [TW-1:0]   e_ot;
        cur   = -1;
        mtype = '0;
        mdone = '0;
        merr  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            e_cfg = 1'b0;
            e_ov  = 1'b0;
            e_ol  = 1'b0;
            e_ir  = '0;
            e_od  = '0;
            e_ot  = '0;
            if (!rst) begin
                if (cur < 0) begin
                    e_cfg = bus.cfg_select_valid & bus.cfg_type_valid;
                end else begin
                    e_ov = bus.in_valid[cur];
                    e_ol = bus.in_last[cur];
                    e_od = bus.in_data[cur*DB +: DB];
                    e_ot = mtype;
                    if (bus.out_ready) e_ir[cur] = 1'b1;
                end
            end
            if (chk_en) begin
                chk("cfg_select_ready", 64'(bus.cfg_select_ready), 64'(e_cfg));
                chk("cfg_type_ready",   64'(bus.cfg_type_ready),   64'(e_cfg));
                chk("in_ready",         64'(bus.in_ready),         64'(e_ir));
                chk("out_valid",        64'(bus.out_valid),        64'(e_ov));
                chk("out_last",         64'(bus.out_last),         64'(e_ol));
                chk("out_data",         64'(bus.out_data),         64'(e_od));
                chk("out_type",         64'(bus.out_type),         64'(e_ot));
                chk("streams_done",     64'(bus.streams_done),     64'(mdone));
                chk("err_bad_select",   64'(bus.err_bad_select),   64'(merr));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                got_q.push_back({bus.out_type, bus.out_last, bus.out_data});
                out_cyc.push_back(cyc);
            end
            if (bus.cfg_select_valid && bus.cfg_select_ready === 1'b1) cfg_hs_n++;
            for (int i = 0; i < NI; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i] === 1'b1) in_hs_n[i]++;
            end
            if (rst) begin
                cur   = -1;
                mtype = '0;
                mdone = '0;
                merr  = 1'b0;
            end else if (cur < 0) begin
                if (bus.cfg_select_valid && bus.cfg_type_valid) begin
                    s = int'(bus.cfg_select_data);
                    if (s < NI) begin
                        cur   = s;
                        mtype = bus.cfg_type_data;
                    end else begin
                        merr = 1'b1;
                    end
                end
            end else if (bus.in_valid[cur] && bus.out_ready && bus.in_last[cur]) begin
                cur   = -1;
                mdone = mdone + 32'd1;
            end
        end
    end

    initial begin : tests
        int             b;
        int             h0;
        int             bad;
        int             nlast;
        int             lastpos;
        logic [DB-1:0]  expd[100];
        logic [TW+DB:0] g;

        // Reset with both config valids high: nothing may handshake
        rst   = 1'b1;
        man_cfg = 1'b1;
        m_sv  = 1'b1;
        m_tv  = 1'b1;
        m_sel = 4'd2;
        m_typ = 4'd5;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_cfg_select_ready", 64'(bus.cfg_select_ready), 64'(0));
        chk("rst_cfg_type_ready",   64'(bus.cfg_type_ready),   64'(0));
        chk("rst_out_valid",        64'(bus.out_valid),        64'(0));
        chk("rst_streams_done",     64'(bus.streams_done),     64'(0));
        chk("rst_err",              64'(bus.err_bad_select),   64'(0));

        // 4-beat stream on port 2, other ports offering junk
        do_reset();
        junk_vld = 1'b1;
        b = got_q.size();
        cfg_q.push_back({4'd2, 4'd5});
        for (int k = 0; k < 4; k++) src_q[2].push_back({1'(k == 3), 32'hA0 + 32'(k)});
        wait_got(b + 4, 60, "t1_timeout");
        for (int k = 0; k < 4; k++) chk_beat("t1_beat", b + k, 32'hA0 + 32'(k), 1'(k == 3), 4'd5);
        chk("t1_streams_done", 64'(bus.streams_done), 64'(1));

        // Select valid alone: no handshake until type valid joins
        do_reset();
        junk_vld = 1'b0;
        b = got_q.size();
        src_q[1].push_back({1'b1, 32'h11});
        man_cfg = 1'b1;
        m_sv  = 1'b1;
        m_tv  = 1'b0;
        m_sel = 4'd1;
        m_typ = 4'd3;
        h0 = cfg_hs_n;
        repeat (10) tick();
        chk("t2_lone_select_ready", 64'(bus.cfg_select_ready), 64'(0));
        chk("t2_no_handshake", 64'(cfg_hs_n - h0), 64'(0));
        m_tv = 1'b1;
        tick();
        chk("t2_join_select_ready", 64'(bus.cfg_select_ready), 64'(1));
        chk("t2_join_type_ready",   64'(bus.cfg_type_ready),   64'(1));
        m_sv = 1'b0;
        m_tv = 1'b0;
        tick();
        chk("t2_one_handshake", 64'(cfg_hs_n - h0), 64'(1));
        chk("t2_out_valid_next", 64'(bus.out_valid), 64'(1));
        wait_got(b + 1, 20, "t2_timeout");
        chk_beat("t2_beat", b, 32'h11, 1'b1, 4'd3);

        // Back-to-back one-beat streams
        do_reset();
        b = got_q.size();
        cfg_q.push_back({4'd0, 4'd1});
        cfg_q.push_back({4'd3, 4'd7});
        src_q[0].push_back({1'b1, 32'hB0});
        src_q[3].push_back({1'b1, 32'hB3});
        wait_got(b + 2, 40, "t3_timeout");
        chk_beat("t3_first", b, 32'hB0, 1'b1, 4'd1);
        chk_beat("t3_second", b + 1, 32'hB3, 1'b1, 4'd7);
        if (out_cyc.size() >= b + 2) chk("t3_gap", 64'(out_cyc[b+1] - out_cyc[b]), 64'(2));
        chk("t3_streams_done", 64'(bus.streams_done), 64'(2));

        // Out-of-range select followed by a valid config
        do_reset();
        b = got_q.size();
        cfg_q.push_back({4'd6, 4'd9});
        cfg_q.push_back({4'd1, 4'd2});
        src_q[1].push_back({1'b0, 32'hC0});
        src_q[1].push_back({1'b1, 32'hC1});
        wait_got(b + 2, 40, "t4_timeout");
        chk_beat("t4_b0", b, 32'hC0, 1'b0, 4'd2);
        chk_beat("t4_b1", b + 1, 32'hC1, 1'b1, 4'd2);
        repeat (3) tick();
        chk("t4_err_sticky", 64'(bus.err_bad_select), 64'(1));
        chk("t4_streams_done", 64'(bus.streams_done), 64'(1));

        // 100-beat stream under random valid and ready
        do_reset();
        junk_vld = 1'b1;
        vld_pct = 70;
        rdy_pct = 50;
        b = got_q.size();
        cfg_q.push_back({4'd3, 4'hE});
        for (int k = 0; k < 100; k++) begin
            expd[k] = DB'($urandom);
            src_q[3].push_back({1'(k == 99), expd[k]});
        end
        wait_got(b + 100, 3000, "t5_timeout");
        repeat (5) tick();
        bad = 0;
        nlast = 0;
        lastpos = -1;
        for (int k = 0; k < 100 && b + k < got_q.size(); k++) begin
            g = got_q[b+k];
            if (g[DB-1:0] !== expd[k] || g[TW+DB:DB+1] !== 4'hE) bad++;
            if (g[DB]) begin
                nlast++;
                lastpos = k;
            end
        end
        chk("t5_bad_beats", 64'(bad), 64'(0));
        chk("t5_last_count", 64'(nlast), 64'(1));
        chk("t5_last_pos", 64'(lastpos), 64'(99));
        chk("t5_beat_count", 64'(got_q.size() - b), 64'(100));
        chk("t5_streams_done", 64'(bus.streams_done), 64'(1));

        // Reset in the middle of an 8-beat stream
        do_reset();
        junk_vld = 1'b0;
        vld_pct = 100;
        rdy_pct = 100;
        b = got_q.size();
        cfg_q.push_back({4'd0, 4'd4});
        for (int k = 0; k < 8; k++) src_q[0].push_back({1'(k == 7), 32'hD0 + 32'(k)});
        wait_got(b + 3, 40, "t6_timeout_pre");
        rst = 1'b1;
        flush_req++;
        tick();
        chk("t6_in_ready",     64'(bus.in_ready),     64'(0));
        chk("t6_out_valid",    64'(bus.out_valid),    64'(0));
        chk("t6_streams_done", 64'(bus.streams_done), 64'(0));
        cfg_q.push_back({4'd2, 4'd6});
        src_q[2].push_back({1'b1, 32'hE2});
        tick();
        chk("t6_cfg_ready_in_rst", 64'(bus.cfg_select_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("t6_cfg_first_idle", 64'(bus.cfg_select_ready), 64'(1));
        chk("t6_beats_before", 64'(got_q.size() - b), 64'(3));
        wait_got(b + 4, 40, "t6_timeout_post");
        chk_beat("t6_beat2", b + 2, 32'hD2, 1'b0, 4'd4);
        chk_beat("t6_new", b + 3, 32'hE2, 1'b1, 4'd6);
        chk("t6_streams_done_after", 64'(bus.streams_done), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
